// File: rtl/core_lsu_pkg.sv
// Shared definitions for the core load/store unit: funct3 access encodings,
// handshake FSM state encodings and the byte-lane count derivation.
package core_lsu_pkg;

    localparam logic [2:0] LIS_B  = 3'b000;
    localparam logic [2:0] LIS_H  = 3'b001;
    localparam logic [2:0] LIS_W  = 3'b010;
    localparam logic [2:0] LIS_BU = 3'b100;
    localparam logic [2:0] LIS_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    function automatic int lsu_transfer_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, access
// legality check and load-data extraction with sign/zero extension.
module core_lsu_align
    import core_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TRANSFER_WIDTH = 4,
    parameter int LIS_OP_WIDTH   = 3,
    parameter int OFF_W          = $clog2(TRANSFER_WIDTH)
) (
    input  logic                      we_i,
    input  logic [LIS_OP_WIDTH-1:0]   lis_op_i,
    input  logic [OFF_W-1:0]          offset_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    output logic [TRANSFER_WIDTH-1:0] be_o,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic                      err_o,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    localparam logic [TRANSFER_WIDTH-1:0] BE_ONE = TRANSFER_WIDTH'(1);
    localparam logic [TRANSFER_WIDTH-1:0] BE_TWO = TRANSFER_WIDTH'(3);

    logic [DATA_WIDTH-1:0] wdata_b;
    logic [DATA_WIDTH-1:0] wdata_h;
    logic [DATA_WIDTH-1:0] lane_shifted;

    // Every lane carries a copy, so the byte enables alone pick the target bytes.
    genvar gi;
    generate
        for (gi = 0; gi < TRANSFER_WIDTH; gi++) begin : g_lane
            assign wdata_b[gi*8 +: 8] = wdata_i[7:0];
            assign wdata_h[gi*8 +: 8] = wdata_i[(gi % 2)*8 +: 8];
        end
    endgenerate

    assign lane_shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        be_o    = '0;
        wdata_o = wdata_i;
        err_o   = 1'b0;
        case (lis_op_i)
            LIS_B, LIS_BU: begin
                be_o    = BE_ONE << offset_i;
                wdata_o = wdata_b;
            end
            LIS_H, LIS_HU: begin
                be_o    = BE_TWO << offset_i;
                wdata_o = wdata_h;
                err_o   = offset_i[0];
            end
            LIS_W: begin
                be_o  = '1;
                err_o = |offset_i;
            end
            default: err_o = 1'b1;
        endcase
        if (we_i && (lis_op_i == LIS_BU || lis_op_i == LIS_HU)) begin
            err_o = 1'b1;
        end
    end

    always_comb begin
        rdata_o = rdata_i;
        case (lis_op_i)
            LIS_B:   rdata_o = {{(DATA_WIDTH-8){lane_shifted[7]}}, lane_shifted[7:0]};
            LIS_BU:  rdata_o = {{(DATA_WIDTH-8){1'b0}}, lane_shifted[7:0]};
            LIS_H:   rdata_o = {{(DATA_WIDTH-16){lane_shifted[15]}}, lane_shifted[15:0]};
            LIS_HU:  rdata_o = {{(DATA_WIDTH-16){1'b0}}, lane_shifted[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit with req/gnt/rvalid data-memory handshake and core stall.
// Optional watchdog on the memory handshake: define CORE_LSU_TIMEOUT_EN.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TRANSFER_WIDTH = lsu_transfer_width(DATA_WIDTH),
    parameter int LIS_OP_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      we_i,
    input  logic [LIS_OP_WIDTH-1:0]   lis_op_i,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                      stall_o,
    output logic                      rsp_valid_o,
    output logic                      rsp_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      err_o,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [TRANSFER_WIDTH-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam int OFF_W = $clog2(TRANSFER_WIDTH);

    lsu_state_e                state_q, state_d;
    logic                      we_q, we_d;
    logic [LIS_OP_WIDTH-1:0]   op_q, op_d;
    logic [OFF_W-1:0]          off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [TRANSFER_WIDTH-1:0] be_q, be_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic                      err_q, err_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

    logic                      idle;
    logic                      al_we;
    logic [LIS_OP_WIDTH-1:0]   al_op;
    logic [OFF_W-1:0]          al_off;
    logic [TRANSFER_WIDTH-1:0] al_be;
    logic [DATA_WIDTH-1:0]     al_wdata;
    logic                      al_err;
    logic [DATA_WIDTH-1:0]     al_rdata;
    logic                      unused_addr;

    assign idle        = (state_q == ST_IDLE);
    assign unused_addr = ^{addr_i[DATA_WIDTH-1:MEM_ADDR_WIDTH+2]};

    // One aligner: live request fields while idle, captured fields afterwards
    // so the same instance also extracts the returning load data.
    assign al_we  = idle ? we_i : we_q;
    assign al_op  = idle ? lis_op_i : op_q;
    assign al_off = idle ? addr_i[OFF_W-1:0] : off_q;

    core_lsu_align #(
        .DATA_WIDTH     (DATA_WIDTH),
        .TRANSFER_WIDTH (TRANSFER_WIDTH),
        .LIS_OP_WIDTH   (LIS_OP_WIDTH),
        .OFF_W          (OFF_W)
    ) u_align (
        .we_i     (al_we),
        .lis_op_i (al_op),
        .offset_i (al_off),
        .wdata_i  (wdata_i),
        .rdata_i  (mem_rdata_i),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .err_o    (al_err),
        .rdata_o  (al_rdata)
    );

`ifdef CORE_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        op_d        = op_q;
        off_d       = off_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        be_d        = be_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d        = we_i;
                    op_d        = lis_op_i;
                    off_d       = addr_i[OFF_W-1:0];
                    rd_d        = rd_addr_i;
                    mem_addr_d  = addr_i[MEM_ADDR_WIDTH+1:2];
                    be_d        = al_be;
                    mem_wdata_d = al_wdata;
                    err_d       = al_err;
                    rdata_d     = '0;
                    state_d     = al_err ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? ST_RESP : ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid_i) begin
                    rdata_d = al_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef CORE_LSU_TIMEOUT_EN
        // Counter restarts whenever REQ or WAIT_R is entered; a completing
        // handshake in the final cycle wins over the timeout.
        cnt_d = '0;
        if ((state_q == ST_REQ || state_q == ST_WAIT_R) && state_d == state_q) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_RESP;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            op_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            be_q        <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            be_q        <= be_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef CORE_LSU_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign req_ready_o = idle;
    assign stall_o     = (idle & req_valid_i) | (state_q == ST_REQ) | (state_q == ST_WAIT_R);
    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign err_o       = (state_q == ST_RESP) & err_q;
    assign rsp_we_o    = (state_q == ST_RESP) & ~we_q & ~err_q & (rd_q != '0);
    assign rd_addr_o   = rd_q;
    assign rdata_o     = rdata_q;

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
Parametrised load/store unit for the RISC-V core. It replaces the fixed single-cycle data-memory path with a req/gnt/rvalid handshake, so the core can use variable-latency data memory.
- Generates byte enables, aligns store data across lanes, and sign- or zero-extends load data.
- Flags misaligned and illegal accesses instead of issuing them to memory.
- Sits between the execution unit (address, rs2, load/store op) and the data memory, and drives a stall to the program counter and register file.

Parameters:
MEM_ADDR_WIDTH, 10, data-memory word-address width
DATA_WIDTH, 32, register and memory word width
TRANSFER_WIDTH, 4, byte lanes; must equal DATA_WIDTH/8
LIS_OP_WIDTH, 3, load/store op width (RISC-V funct3 encoding)
REG_ADDR_WIDTH, 5, destination register index width
TIMEOUT_CYCLES, 64, watchdog limit; used only with CORE_LSU_TIMEOUT_EN

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  execution unit presents an access
req_ready_o  out  1  LSU can accept an access
we_i  in  1  1 = store, 0 = load
lis_op_i  in  LIS_OP_WIDTH  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  in  DATA_WIDTH  byte address (rs1 + imm)
wdata_i  in  DATA_WIDTH  store data (rs2)
rd_addr_i  in  REG_ADDR_WIDTH  load destination register
stall_o  out  1  freeze PC and register-file writes
rsp_valid_o  out  1  access complete, one-cycle pulse
rsp_we_o  out  1  register write enable for load result
rd_addr_o  out  REG_ADDR_WIDTH  destination register of response
rdata_o  out  DATA_WIDTH  extended load data
err_o  out  1  misaligned, illegal or timed-out access, valid with rsp_valid_o
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_we_o  out  1  memory write enable
mem_addr_o  out  MEM_ADDR_WIDTH  word address, addr_i[MEM_ADDR_WIDTH+1:2]
mem_be_o  out  TRANSFER_WIDTH  byte enables
mem_wdata_o  out  DATA_WIDTH  lane-aligned store data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Clocking and reset: single clock; asynchronous active-low reset on rst_n.
- Reset values: state IDLE. All outputs are 0 except req_ready_o = 1.
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, capture we_i, lis_op_i, addr_i, wdata_i and rd_addr_i.
  - Legal access: go to REQ.
  - Illegal funct3 (011, 110, 111), store with op 100/101, halfword with addr[0] = 1, or word with addr[1:0] != 0: go to RESP with err = 1; no memory access is issued.
- REQ:
  - mem_req_o = 1; mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are registered and held stable until mem_gnt_i.
  - On grant: a store goes to RESP, a load goes to WAIT_R.
- WAIT_R:
  - mem_rvalid_i is sampled only in this state; the earliest valid cycle is the one after the grant.
  - On rvalid, register the extended data and go to RESP.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, then IDLE.
  - rsp_we_o = load & !err & (rd_addr != 0).
- stall_o = (IDLE & req_valid_i) | REQ | WAIT_R. It is combinational and is 0 in RESP, so writeback and PC advance happen in the same cycle.
- Latency: a load with a zero-wait grant and rvalid on the next cycle takes 4 cycles from accept to rsp_valid_o. A store takes 3 cycles. An error takes 2 cycles.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
- Store data: the byte is replicated ×4 and the half ×2 across lanes.
- Load extraction: select the lane by addr[1:0]. B and H are sign-extended; BU and HU are zero-extended.
- rvalid or gnt arriving in IDLE or RESP is ignored.
- Reset mid-transaction: immediate return to IDLE, mem_req_o drops asynchronously, and a late rvalid after reset is ignored.

Optional Feature:
CORE_LSU_TIMEOUT_EN:
- Defined: a counter is cleared on entry to REQ and WAIT_R and increments each cycle in those states. When it reaches TIMEOUT_CYCLES, the LSU goes to RESP with err = 1 and rsp_we_o = 0, and mem_req_o drops.
- Undefined: no counter is built, and the LSU waits indefinitely.

Decomposition:
- Shared package/defines.vh: funct3 encodings (LIS_B, LIS_H, LIS_W, LIS_BU, LIS_HU), LSU state encodings, and the TRANSFER_WIDTH derivation.
- One sub-module: core_lsu_align. It is combinational and produces mem_be_o, the aligned wdata, the misalign/illegal flag and the extended rdata. Instantiate it once for the store path and the check, and reuse it for load extraction.

Test Plan:
- LW at addr 0x0000_0008 with gnt in the same cycle and rvalid the next cycle, mem_rdata = 0xDEAD_BEEF → mem_addr_o = 2, be = 1111; rsp_valid_o 4 cycles after accept; rdata_o = 0xDEAD_BEEF; rd_addr echoed.
- LB at addr 0x3 with mem_rdata = 0x8000_0000 → rdata_o = 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at addr 0x2 with wdata 0x1234_ABCD → be = 1100, mem_wdata_o = 0xABCD_ABCD; rsp_valid_o with rsp_we_o = 0.
- LW at addr 0x6 → err_o = 1 with rsp_valid_o 2 cycles after accept; mem_req_o never asserted.
- Grant withheld 5 cycles → mem_* fields stable and stall_o = 1 throughout; rst_n pulsed low in WAIT_R → outputs return to reset values immediately; a later rvalid produces no rsp_valid_o.
- With CORE_LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 8, rvalid never arrives → err_o = 1 and rsp_valid_o 8 cycles after entering WAIT_R.
